// File: rtl/dac_pkg.sv
// dac_pkg: shared constants for the DAC serial transmitter.
//   - FSM state encodings (legacy 2-bit constants)
//   - default frame width and guard length
//   - counter width helper
package dac_pkg;

  localparam logic [1:0] ST_REPOSO = 2'd0;
  localparam logic [1:0] ST_ENVIO  = 2'd1;
  localparam logic [1:0] ST_GUARDA = 2'd2;

  localparam int unsigned ANCHO_DEF  = 16;
  localparam int unsigned GUARDA_DEF = 1;

  // Width needed to count 0..n-1; never narrower than one bit.
  function automatic int unsigned ancho_cnt(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/envio_serial_dac_contador.sv
// contador_modulo: modulo-N up-counter.
//   CLK1MHz : clock
//   Reset   : synchronous, active-high clear
//   clr     : synchronous clear (takes priority over en)
//   en      : count enable; wraps from N-1 to 0
//   cuenta  : current count, W bits
module contador_modulo #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic         CLK1MHz,
  input  logic         Reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cuenta
);

  always_ff @(posedge CLK1MHz) begin
    if (Reset || clr) begin
      cuenta <= '0;
    end else if (en) begin
      if (cuenta == W'(N - 1)) cuenta <= '0;
      else                     cuenta <= cuenta + 1'b1;
    end
  end

endmodule

// File: rtl/envio_serial_dac.sv
// envio_serial_dac: parallel-to-serial transmitter for the DAC.
// Accepts a word on Valid && Ready and shifts it out MSB first while SYNC
// is low; CLK1MHz doubles as the DAC SCLK (DAC samples on falling edge).
//   CLK1MHz     : clock / SCLK
//   Reset       : synchronous, active-high
//   DinParalelo : word to send (sampled only at the accept edge)
//   Valid       : DinParalelo valid
//   Ready       : block can accept a word
//   SYNC        : active-low frame select
//   DoutSerial  : serial data, MSB first
//   Busy        : high in ENVIO or GUARDA
//   Done        : one-cycle pulse after the last bit
// Optional build macro DAC_DOBLE_BUFFER_EN adds a one-word holding register
// so a new word can be accepted while a frame is in flight.
module envio_serial_dac
  import dac_pkg::*;
#(
  parameter int unsigned ANCHO  = ANCHO_DEF,
  parameter int unsigned GUARDA = GUARDA_DEF
) (
  input  logic             CLK1MHz,
  input  logic             Reset,
  input  logic [ANCHO-1:0] DinParalelo,
  input  logic             Valid,
  output logic             Ready,
  output logic             SYNC,
  output logic             DoutSerial,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = ancho_cnt(ANCHO);
  localparam int unsigned GW = ancho_cnt(GUARDA);

  logic [1:0]       estado;
  logic [ANCHO-1:0] desplaza;
  logic [CW-1:0]    cnt_bit;
  logic [GW-1:0]    cnt_guarda;
  logic             acepta;
  logic             inicio;
  logic [ANCHO-1:0] palabra;
  logic             ultimo_bit;
  logic             ultimo_guarda;

  assign acepta        = Valid && Ready;
  assign ultimo_bit    = (estado == ST_ENVIO)  && (cnt_bit    == CW'(ANCHO - 1));
  assign ultimo_guarda = (estado == ST_GUARDA) && (cnt_guarda == GW'(GUARDA - 1));

`ifdef DAC_DOBLE_BUFFER_EN
  logic             lleno;
  logic [ANCHO-1:0] retencion;
  logic             recarga;

  assign Ready = !Reset && !lleno;
  // A held word starts at the last guard edge, or from REPOSO if it was
  // captured on that same edge and the FSM fell back to idle.
  assign recarga = lleno && (ultimo_guarda || (estado == ST_REPOSO));
  assign inicio  = recarga || (acepta && (estado == ST_REPOSO));
  assign palabra = recarga ? retencion : DinParalelo;

  always_ff @(posedge CLK1MHz) begin
    if (Reset) begin
      lleno     <= 1'b0;
      retencion <= '0;
    end else if (acepta && (estado != ST_REPOSO)) begin
      lleno     <= 1'b1;
      retencion <= DinParalelo;
    end else if (recarga) begin
      lleno     <= 1'b0;
    end
  end
`else
  assign Ready   = !Reset && (estado == ST_REPOSO);
  assign inicio  = acepta;
  assign palabra = DinParalelo;
`endif

  contador_modulo #(
    .N (ANCHO),
    .W (CW)
  ) u_cnt_bit (
    .CLK1MHz (CLK1MHz),
    .Reset   (Reset),
    .clr     (inicio),
    .en      (estado == ST_ENVIO),
    .cuenta  (cnt_bit)
  );

  contador_modulo #(
    .N (GUARDA),
    .W (GW)
  ) u_cnt_guarda (
    .CLK1MHz (CLK1MHz),
    .Reset   (Reset),
    .clr     (ultimo_bit),
    .en      (estado == ST_GUARDA),
    .cuenta  (cnt_guarda)
  );

  always_ff @(posedge CLK1MHz) begin
    if (Reset) begin
      estado   <= ST_REPOSO;
      desplaza <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= ultimo_bit;
      case (estado)
        ST_REPOSO: begin
          if (inicio) begin
            estado   <= ST_ENVIO;
            desplaza <= palabra;
          end
        end
        ST_ENVIO: begin
          if (ultimo_bit) begin
            estado   <= ST_GUARDA;
            desplaza <= '0;
          end else begin
            desplaza <= {desplaza[ANCHO-2:0], 1'b0};
          end
        end
        ST_GUARDA: begin
          if (ultimo_guarda) begin
            if (inicio) begin
              estado   <= ST_ENVIO;
              desplaza <= palabra;
            end else begin
              estado   <= ST_REPOSO;
            end
          end
        end
        default: begin
          estado   <= ST_REPOSO;
          desplaza <= '0;
        end
      endcase
    end
  end

  assign SYNC       = (estado != ST_ENVIO);
  assign DoutSerial = (estado == ST_ENVIO) && desplaza[ANCHO-1];
  assign Busy       = (estado == ST_ENVIO) || (estado == ST_GUARDA);

endmodule
